// File: rtl/tl_mem_responder.sv
// rtl/tl_mem_responder.sv - TileLink-UL/AL responder over a single-ported word RAM with LR/SC reservation
module tl_mem_responder #(
  parameter int          ADDR_W = 16,
  parameter logic [63:0] BASE   = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [2:0]  a_size,
  input  logic [7:0]  a_mask,
  input  logic [63:0] a_address,
  input  logic [63:0] a_data,
  input  logic [3:0]  a_source,
  input  logic        a_corrupt,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_opcode,
  output logic [2:0]  d_size,
  output logic [3:0]  d_source,
  output logic [63:0] d_data,
  output logic        d_denied
);

  localparam int IDX_W = ADDR_W - 3;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [2:0] TL_PUT_F      = 3'd0;
  localparam logic [2:0] TL_ARITH_DATA = 3'd2;
  localparam logic [2:0] TL_LOGIC_DATA = 3'd3;
  localparam logic [2:0] TL_GET        = 3'd4;

  localparam logic [2:0] TL_PARAM_MIN  = 3'd0;
  localparam logic [2:0] TL_PARAM_MAX  = 3'd1;
  localparam logic [2:0] TL_PARAM_MINU = 3'd2;
  localparam logic [2:0] TL_PARAM_MAXU = 3'd3;
  localparam logic [2:0] TL_PARAM_ADD  = 3'd4;
  localparam logic [2:0] TL_PARAM_XOR  = 3'd0;
  localparam logic [2:0] TL_PARAM_OR   = 3'd1;
  localparam logic [2:0] TL_PARAM_AND  = 3'd2;
  localparam logic [2:0] TL_PARAM_SWAP = 3'd3;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;
  state_t state, state_nxt;

  logic [63:0] mem [DEPTH];
  logic [63:0] rd_q;

  logic [2:0]  op_q, param_q, size_q;
  logic [7:0]  mask_q;
  logic [63:0] addr_q, data_q;
  logic [3:0]  source_q;
  logic        corrupt_q;

  logic             resv_valid;
  logic [IDX_W-1:0] resv_idx;

  logic             accept;
  logic [IDX_W-1:0] a_idx, q_idx;
  logic [5:0]       a_sh, q_sh;
  logic [63:0]      a_rel, q_rel;
  logic             a_in_range, q_in_range;
  logic             a_is_put, a_is_get, a_is_amo, a_to_read, q_is_amo;
  logic             sc_ok, put_write;

  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_idx;
  logic [63:0]      ram_wdata;
  logic [7:0]       ram_wmask;

  logic [63:0] old_word, amo_new;
  logic [63:0] op_a_s, op_b_s, op_a_u, op_b_u;
  logic        is_w, lt_s, lt_u;

  assign accept     = a_valid && (state == IDLE);
  assign a_idx      = a_address[ADDR_W-1:3];
  assign a_sh       = {a_address[2:0], 3'b000};
  assign a_rel      = a_address - BASE;
  assign a_in_range = (a_rel >> ADDR_W) == '0;
  assign q_idx      = addr_q[ADDR_W-1:3];
  assign q_sh       = {addr_q[2:0], 3'b000};
  assign q_rel      = addr_q - BASE;
  assign q_in_range = (q_rel >> ADDR_W) == '0;

  assign a_is_put  = (a_opcode == TL_PUT_F);
  assign a_is_get  = (a_opcode == TL_GET);
  assign a_is_amo  = (a_opcode == TL_ARITH_DATA) || (a_opcode == TL_LOGIC_DATA);
  assign a_to_read = a_is_get || a_is_amo;
  assign q_is_amo  = (op_q == TL_ARITH_DATA) || (op_q == TL_LOGIC_DATA);

  // A plain Put always writes in range; an SC writes only while holding the reservation.
  assign sc_ok     = resv_valid && (resv_idx == a_idx);
  assign put_write = accept && a_is_put && a_in_range && (!a_corrupt || sc_ok);

  // Word atomics compare on bit 31 by extending the low half before the 64-bit compare.
  assign old_word = rd_q >> q_sh;
  assign is_w     = (size_q == 3'd2);
  assign op_a_s   = is_w ? {{32{old_word[31]}}, old_word[31:0]} : old_word;
  assign op_b_s   = is_w ? {{32{data_q[31]}}, data_q[31:0]} : data_q;
  assign op_a_u   = is_w ? {32'b0, old_word[31:0]} : old_word;
  assign op_b_u   = is_w ? {32'b0, data_q[31:0]} : data_q;
  assign lt_s     = $signed(op_a_s) < $signed(op_b_s);
  assign lt_u     = op_a_u < op_b_u;

  always_comb begin
    amo_new = data_q;
    if (op_q == TL_ARITH_DATA) begin
      case (param_q)
        TL_PARAM_MIN:  amo_new = lt_s ? old_word : data_q;
        TL_PARAM_MAX:  amo_new = lt_s ? data_q : old_word;
        TL_PARAM_MINU: amo_new = lt_u ? old_word : data_q;
        TL_PARAM_MAXU: amo_new = lt_u ? data_q : old_word;
        TL_PARAM_ADD:  amo_new = old_word + data_q;
        default:       amo_new = old_word;
      endcase
    end else begin
      case (param_q)
        TL_PARAM_XOR:  amo_new = old_word ^ data_q;
        TL_PARAM_OR:   amo_new = old_word | data_q;
        TL_PARAM_AND:  amo_new = old_word & data_q;
        TL_PARAM_SWAP: amo_new = data_q;
        default:       amo_new = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = a_to_read ? READ : RESP;
      READ:    state_nxt = RESP;
      RESP:    if (d_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_ready   = (state == IDLE);
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_idx   = a_idx;
    ram_wdata = a_data << a_sh;
    ram_wmask = a_mask;
    case (state)
      IDLE: begin
        ram_we = put_write;
        ram_re = accept && a_to_read && a_in_range;
      end
      READ: begin
        ram_idx   = q_idx;
        ram_wdata = amo_new << q_sh;
        ram_wmask = mask_q;
        ram_we    = q_is_amo && q_in_range;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 8; i++) begin
        if (ram_wmask[i]) mem[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_re) rd_q <= mem[ram_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      param_q    <= '0;
      size_q     <= '0;
      mask_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      source_q   <= '0;
      corrupt_q  <= 1'b0;
      resv_valid <= 1'b0;
      resv_idx   <= '0;
      d_valid    <= 1'b0;
      d_opcode   <= '0;
      d_size     <= '0;
      d_source   <= '0;
      d_data     <= '0;
      d_denied   <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= a_opcode;
        param_q   <= a_param;
        size_q    <= a_size;
        mask_q    <= a_mask;
        addr_q    <= a_address;
        data_q    <= a_data;
        source_q  <= a_source;
        corrupt_q <= a_corrupt;
      end

      if (accept && a_is_put && a_in_range) begin
        if (a_corrupt || (put_write && resv_idx == a_idx)) resv_valid <= 1'b0;
      end
      if (state == READ && q_in_range) begin
        if (op_q == TL_GET && corrupt_q) begin
          resv_valid <= 1'b1;
          resv_idx   <= q_idx;
        end else if (q_is_amo && resv_idx == q_idx) begin
          resv_valid <= 1'b0;
        end
      end

      if (state == RESP && d_ready) d_valid <= 1'b0;

      // Put, SC and unknown opcodes answer straight from IDLE.
      if (accept && !a_to_read) begin
        d_valid  <= 1'b1;
        d_opcode <= (a_is_put && a_corrupt) ? 3'd1 : 3'd0;
        d_size   <= a_size;
        d_source <= a_source;
        d_denied <= !a_is_put || !a_in_range;
        d_data   <= (a_is_put && a_corrupt && a_in_range && !sc_ok) ? 64'd1 : 64'd0;
      end
      if (state == READ) begin
        d_valid  <= 1'b1;
        d_opcode <= 3'd1;
        d_size   <= size_q;
        d_source <= source_q;
        d_denied <= !q_in_range;
        d_data   <= q_in_range ? old_word : 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_tl_mem_responder.sv
// tb/tb_tl_mem_responder.sv - directed self-checking bench for tl_mem_responder
module tb_tl_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [2:0]  a_opcode = '0;
  logic [2:0]  a_param = '0;
  logic [2:0]  a_size = '0;
  logic [7:0]  a_mask = '0;
  logic [63:0] a_address = '0;
  logic [63:0] a_data = '0;
  logic [3:0]  a_source = '0;
  logic        a_corrupt = 1'b0;
  logic        d_valid;
  logic        d_ready = 1'b0;
  logic [2:0]  d_opcode;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic [63:0] d_data;
  logic        d_denied;

  localparam logic [2:0] OP_PUT = 3'd0, OP_PARTIAL = 3'd1, OP_ARITH = 3'd2, OP_LOGIC = 3'd3, OP_GET = 3'd4;

  int passed = 0;
  int total = 0;
  int beats = 0;

  int          obs_lat;
  logic [63:0] obs_data;
  logic [2:0]  obs_opc;
  logic [2:0]  obs_size;
  logic [3:0]  obs_src;
  logic        obs_den;
  logic [3:0]  src_next = 4'h1;
  logic [3:0]  exp_src;

  tl_mem_responder #(.ADDR_W(16), .BASE(64'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_mask(a_mask), .a_address(a_address), .a_data(a_data),
    .a_source(a_source), .a_corrupt(a_corrupt),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_data(d_data), .d_denied(d_denied)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (d_valid && d_ready) beats <= beats + 1;

  task automatic tl_req(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                        input logic [7:0] mask, input logic [63:0] addr, input logic [63:0] data,
                        input logic corrupt);
    int n;
    @(negedge clk);
    a_opcode = op; a_param = param; a_size = size; a_mask = mask;
    a_address = addr; a_data = data; a_corrupt = corrupt;
    a_source = src_next; exp_src = src_next; src_next = src_next + 4'd1;
    a_valid = 1'b1; d_ready = 1'b1;
    @(posedge clk);
    obs_lat = -1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (d_valid) begin
        obs_lat = n;
        break;
      end
    end
    obs_data = d_data; obs_opc = d_opcode; obs_size = d_size; obs_src = d_source; obs_den = d_denied;
    if (obs_lat > 0) @(posedge clk);
    #1 a_valid = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (a_ready !== 1'b1) $display("FAIL reset_a_ready: got %b want 1", a_ready); else passed++;
    total++; if (d_valid !== 1'b0) $display("FAIL reset_d_valid: got %b want 0", d_valid); else passed++;
    total++; if (d_denied !== 1'b0) $display("FAIL reset_d_denied: got %b want 0", d_denied); else passed++;
    total++; if (d_data !== 64'h0) $display("FAIL reset_d_data: got %h want 0", d_data); else passed++;
    total++; if ({d_opcode, d_size, d_source} !== 10'h0) $display("FAIL reset_d_fields: got %h want 0", {d_opcode, d_size, d_source}); else passed++;
  endtask

  task automatic test_put_get();
    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h8, 64'h1122334455667788, 1'b0);
    total++; if (obs_lat !== 1) $display("FAIL put_latency: got %0d want 1", obs_lat); else passed++;
    total++; if (obs_opc !== 3'd0) $display("FAIL put_opcode: got %0d want 0", obs_opc); else passed++;
    total++; if (obs_data !== 64'h0) $display("FAIL put_data: got %h want 0", obs_data); else passed++;
    total++; if (obs_src !== exp_src) $display("FAIL put_source: got %h want %h", obs_src, exp_src); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h8, 64'h0, 1'b0);
    total++; if (obs_lat !== 2) $display("FAIL get_latency: got %0d want 2", obs_lat); else passed++;
    total++; if (obs_opc !== 3'd1) $display("FAIL get_opcode: got %0d want 1", obs_opc); else passed++;
    total++; if (obs_data !== 64'h1122334455667788) $display("FAIL get_data: got %h want 1122334455667788", obs_data); else passed++;
    total++; if (obs_size !== 3'd3) $display("FAIL get_size: got %0d want 3", obs_size); else passed++;
    total++; if (obs_den !== 1'b0) $display("FAIL get_denied: got %b want 0", obs_den); else passed++;
  endtask

  task automatic test_subword();
    tl_req(OP_PUT, 3'd0, 3'd0, 8'h20, 64'hD, 64'hA5, 1'b0);
    total++; if (obs_lat !== 1) $display("FAIL putb_latency: got %0d want 1", obs_lat); else passed++;
    tl_req(OP_GET, 3'd0, 3'd0, 8'h20, 64'hD, 64'h0, 1'b0);
    total++; if (obs_data[7:0] !== 8'hA5) $display("FAIL getb_data: got %h want a5", obs_data[7:0]); else passed++;
    total++; if (obs_size !== 3'd0) $display("FAIL getb_size: got %0d want 0", obs_size); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h8, 64'h0, 1'b0);
    total++; if (obs_data !== 64'h1122A54455667788) $display("FAIL getb_word: got %h want 1122a54455667788", obs_data); else passed++;
  endtask

  task automatic test_atomic();
    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h10, 64'h00000000FFFFFFFF, 1'b0);
    tl_req(OP_ARITH, 3'd4, 3'd2, 8'h0F, 64'h10, 64'h1, 1'b0);
    total++; if (obs_lat !== 2) $display("FAIL amoadd_latency: got %0d want 2", obs_lat); else passed++;
    total++; if (obs_data !== 64'h00000000FFFFFFFF) $display("FAIL amoadd_old: got %h want ffffffff", obs_data); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h10, 64'h0, 1'b0);
    total++; if (obs_data !== 64'h0) $display("FAIL amoadd_mem: got %h want 0", obs_data); else passed++;

    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h10, 64'h00000000FFFFFFFF, 1'b0);
    tl_req(OP_ARITH, 3'd1, 3'd2, 8'h0F, 64'h10, 64'h5, 1'b0);
    total++; if (obs_data !== 64'h00000000FFFFFFFF) $display("FAIL amomax_old: got %h want ffffffff", obs_data); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h10, 64'h0, 1'b0);
    total++; if (obs_data !== 64'h5) $display("FAIL amomax_mem: got %h want 5", obs_data); else passed++;

    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h10, 64'h00000000FFFFFFFF, 1'b0);
    tl_req(OP_ARITH, 3'd3, 3'd2, 8'h0F, 64'h10, 64'h5, 1'b0);
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h10, 64'h0, 1'b0);
    total++; if (obs_data !== 64'h00000000FFFFFFFF) $display("FAIL amomaxu_mem: got %h want ffffffff", obs_data); else passed++;

    tl_req(OP_LOGIC, 3'd1, 3'd3, 8'hFF, 64'h10, 64'hF000000000000000, 1'b0);
    total++; if (obs_data !== 64'h00000000FFFFFFFF) $display("FAIL amoor_old: got %h want ffffffff", obs_data); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h10, 64'h0, 1'b0);
    total++; if (obs_data !== 64'hF0000000FFFFFFFF) $display("FAIL amoor_mem: got %h want f0000000ffffffff", obs_data); else passed++;
  endtask

  task automatic test_lrsc();
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h0, 1'b1);
    total++; if (obs_lat !== 2) $display("FAIL lr_latency: got %0d want 2", obs_lat); else passed++;
    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h7, 1'b1);
    total++; if (obs_lat !== 1) $display("FAIL sc_latency: got %0d want 1", obs_lat); else passed++;
    total++; if (obs_opc !== 3'd1) $display("FAIL sc_opcode: got %0d want 1", obs_opc); else passed++;
    total++; if (obs_data !== 64'h0) $display("FAIL sc_ok_data: got %h want 0", obs_data); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h0, 1'b0);
    total++; if (obs_data !== 64'h7) $display("FAIL sc_ok_mem: got %h want 7", obs_data); else passed++;

    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h9, 1'b1);
    total++; if (obs_data !== 64'h1) $display("FAIL sc_again_data: got %h want 1", obs_data); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h0, 1'b0);
    total++; if (obs_data !== 64'h7) $display("FAIL sc_again_mem: got %h want 7", obs_data); else passed++;

    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h0, 1'b1);
    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h55, 1'b0);
    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h9, 1'b1);
    total++; if (obs_data !== 64'h1) $display("FAIL sc_after_put_data: got %h want 1", obs_data); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h20, 64'h0, 1'b0);
    total++; if (obs_data !== 64'h55) $display("FAIL sc_after_put_mem: got %h want 55", obs_data); else passed++;
  endtask

  task automatic test_denied();
    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h0, 64'hCAFE, 1'b0);
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h10000, 64'h0, 1'b0);
    total++; if (obs_den !== 1'b1) $display("FAIL deny_get_denied: got %b want 1", obs_den); else passed++;
    total++; if (obs_data !== 64'h0) $display("FAIL deny_get_data: got %h want 0", obs_data); else passed++;
    total++; if (obs_lat !== 2) $display("FAIL deny_get_latency: got %0d want 2", obs_lat); else passed++;
    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h10000, 64'hDEAD, 1'b0);
    total++; if ({obs_den, obs_opc} !== 4'b1000) $display("FAIL deny_put_resp: got %b want 1000", {obs_den, obs_opc}); else passed++;
    tl_req(OP_PARTIAL, 3'd0, 3'd3, 8'hFF, 64'h0, 64'hBEEF, 1'b0);
    total++; if ({obs_den, obs_opc} !== 4'b1000) $display("FAIL unknown_resp: got %b want 1000", {obs_den, obs_opc}); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h0, 64'h0, 1'b0);
    total++; if (obs_data !== 64'hCAFE) $display("FAIL deny_ram_untouched: got %h want cafe", obs_data); else passed++;
  endtask

  task automatic test_handshake();
    int b0;
    int n;
    @(negedge clk);
    a_opcode = OP_GET; a_param = 3'd0; a_size = 3'd3; a_mask = 8'hFF;
    a_address = 64'h8; a_data = 64'h0; a_corrupt = 1'b0; a_source = 4'h9;
    a_valid = 1'b1; d_ready = 1'b0;
    b0 = beats;
    n = 0;
    while (!d_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++; if (d_valid !== 1'b1) $display("FAIL hs_response: got %b want 1", d_valid); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++; if (d_data !== 64'h1122A54455667788) $display("FAIL hs_stable_data%0d: got %h want 1122a54455667788", k, d_data); else passed++;
      total++; if ({d_valid, d_source, a_ready} !== 6'b1_1001_0) $display("FAIL hs_stable_ctl%0d: got %b want 110010", k, {d_valid, d_source, a_ready}); else passed++;
      @(negedge clk);
    end
    d_ready = 1'b1;
    @(posedge clk);
    #1 a_valid = 1'b0;
    @(negedge clk);
    total++; if ({a_ready, d_valid} !== 2'b10) $display("FAIL hs_release: got %b want 10", {a_ready, d_valid}); else passed++;
    @(negedge clk);
    total++; if (beats - b0 !== 1) $display("FAIL hs_one_beat: got %0d want 1", beats - b0); else passed++;
  endtask

  task automatic test_reset_abort();
    int b0;
    tl_req(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h30, 64'h100, 1'b0);
    b0 = beats;
    @(negedge clk);
    a_opcode = OP_LOGIC; a_param = 3'd3; a_size = 3'd3; a_mask = 8'hFF;
    a_address = 64'h30; a_data = 64'h999; a_corrupt = 1'b0; a_valid = 1'b1; d_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if ({a_ready, d_valid} !== 2'b00) $display("FAIL abort_in_read: got %b want 00", {a_ready, d_valid}); else passed++;
    rst_n = 1'b0;
    a_valid = 1'b0;
    #1;
    total++; if ({a_ready, d_valid} !== 2'b10) $display("FAIL abort_reset: got %b want 10", {a_ready, d_valid}); else passed++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (beats !== b0) $display("FAIL abort_no_beat: got %0d want %0d", beats, b0); else passed++;
    tl_req(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h30, 64'h0, 1'b0);
    total++; if (obs_data !== 64'h100) $display("FAIL abort_ram_unchanged: got %h want 100", obs_data); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
    $fatal(1);
  end

  initial begin
    #2;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_put_get();
    test_subword();
    test_atomic();
    test_lrsc();
    test_denied();
    test_handshake();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
